// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier.
// Round-to-nearest-even, flush-to-zero, valid/ready with tag.
`timescale 1ns/1ps
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_s,
    input  logic [EXP_W+MAN_W:0] in_t,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_d,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2:0]           out_flags
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EW2 = EXP_W + 2;

    localparam logic [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QBIT =
        {{(W - MAN_W){1'b0}}, 1'b1, {(MAN_W - 1){1'b0}}};
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    logic advance;

    // stage 1: captured operands
    logic             v1;
    logic [W-1:0]     s1_q;
    logic [W-1:0]     t1_q;
    logic [TAG_W-1:0] tag1_q;

    // stage 2: classified operation and raw product
    logic                  v2;
    logic                  sign2;
    logic signed [EW2-1:0] exp2;
    logic [PW-1:0]         prod2;
    logic                  spc2;
    logic [W-1:0]          spcd2;
    logic                  inv2;
    logic [TAG_W-1:0]      tag2;

    // stage 1 combinational
    logic [EXP_W-1:0]      s_e, t_e;
    logic [MAN_W-1:0]      s_m, t_m;
    logic                  s_zero, t_zero, s_inf, t_inf, s_nan, t_nan;
    logic                  sign1;
    logic signed [EW2-1:0] exp_sum;
    logic [PW-1:0]         prod;
    logic                  spc;
    logic [W-1:0]          spc_d;
    logic                  inv;

    // stage 2 combinational
    logic [PW-1:0]         norm;
    logic [SW-1:0]         mant;
    logic                  guard, sticky, inc, carry;
    logic [MAN_W-1:0]      frac;
    logic signed [EW2-1:0] e_n, e_r;
    logic [W-1:0]          res;
    logic [2:0]            flg;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign s_e = s1_q[W-2:MAN_W];
    assign t_e = t1_q[W-2:MAN_W];
    assign s_m = s1_q[MAN_W-1:0];
    assign t_m = t1_q[MAN_W-1:0];

    // classify operands, form sign, exponent sum and product
    always_comb begin
        s_zero  = (s_e == '0);
        t_zero  = (t_e == '0);
        s_inf   = (&s_e) && !(|s_m);
        t_inf   = (&t_e) && !(|t_m);
        s_nan   = (&s_e) && (|s_m);
        t_nan   = (&t_e) && (|t_m);
        sign1   = s1_q[W-1] ^ t1_q[W-1];
        exp_sum = $signed({2'b00, s_e}) + $signed({2'b00, t_e})
                - $signed(BIAS);
        prod    = PW'({1'b1, s_m}) * PW'({1'b1, t_m});
        spc     = 1'b1;
        spc_d   = '0;
        inv     = 1'b0;
        if (s_nan) begin
            spc_d = s1_q | QBIT;
        end else if (t_nan) begin
            spc_d = t1_q | QBIT;
        end else if ((s_inf && t_zero) || (t_inf && s_zero)) begin
            spc_d = QNAN;
            inv   = 1'b1;
        end else if (s_inf || t_inf) begin
            spc_d = {sign1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s_zero || t_zero) begin
            spc_d = {sign1, {(W - 1){1'b0}}};
        end else begin
            spc   = 1'b0;
        end
    end

    // normalise, round to nearest even, range check and pack
    always_comb begin
        norm   = prod2[PW-1] ? prod2 : (prod2 << 1);
        e_n    = exp2 + {{(EW2 - 1){1'b0}}, prod2[PW-1]};
        mant   = norm[PW-1 -: SW];
        guard  = norm[PW-SW-1];
        sticky = |norm[PW-SW-2:0];
        inc    = guard && (sticky || mant[0]);
        carry  = inc && (&mant);
        frac   = mant[MAN_W-1:0] + MAN_W'(inc);
        e_r    = e_n + {{(EW2 - 1){1'b0}}, carry};
        res    = {sign2, e_r[EXP_W-1:0], frac};
        flg    = 3'b000;
        if (spc2) begin
            res = spcd2;
            flg = {inv2, 2'b00};
        end else if (e_r >= EMAX) begin
            res = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 3'b010;
        end else if (e_r[EW2-1] || (e_r == '0)) begin
            res = {sign2, {(W - 1){1'b0}}};
            flg = 3'b001;
        end
    end

    // valid bits and output registers shift together on advance
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_d     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_d     <= res;
                out_tag   <= tag2;
                out_flags <= flg;
            end
        end
    end

    // stage 1 and stage 2 payload, loaded only for real operations
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s1_q   <= in_s;
            t1_q   <= in_t;
            tag1_q <= in_tag;
        end
        if (advance && v1) begin
            sign2 <= sign1;
            exp2  <= exp_sum;
            prod2 <= prod;
            spc2  <= spc;
            spcd2 <= spc_d;
            inv2  <= inv;
            tag2  <= tag1_q;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe (binary32 config).
// Exact integer reference model, random bubbles and backpressure.
`timescale 1ns/1ps
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_s = '0;
    logic [31:0] in_t = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_d;
    logic [3:0]  out_tag;
    logic [2:0]  out_flags;

    fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_t(in_t), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  tag;
        logic [2:0]  fl;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cycle = 0;
    int          stalls = 0;
    int          lat;
    logic [31:0] exp_d = '0;
    logic [2:0]  exp_f = '0;
    bit          have_hold = 0;
    logic [31:0] hd;
    logic [3:0]  ht;
    logic [2:0]  hf;
    bit          done = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // exact reference: integer product, explicit tie-to-even rounding
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] f);
        bit     sg = a[31] ^ b[31];
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        longint ma = longint'(a[22:0]);
        longint mb = longint'(b[22:0]);
        bit     a_nan = (ea == 255) && (ma != 0);
        bit     b_nan = (eb == 255) && (mb != 0);
        bit     a_inf = (ea == 255) && (ma == 0);
        bit     b_inf = (eb == 255) && (mb == 0);
        bit     a_zero = (ea == 0);
        bit     b_zero = (eb == 0);
        longint p, q, rem, half;
        int     k, ex;
        f = 3'b000;
        r = '0;
        if (a_nan) r = a | 32'h0040_0000;
        else if (b_nan) r = b | 32'h0040_0000;
        else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            r = 32'h7FC0_0000;
            f = 3'b100;
        end else if (a_inf || b_inf) r = {sg, 8'hFF, 23'h0};
        else if (a_zero || b_zero) r = {sg, 31'h0};
        else begin
            p    = (ma + (longint'(1) << 23)) * (mb + (longint'(1) << 23));
            k    = (p >= (longint'(1) << 47)) ? 24 : 23;
            q    = p >> k;
            rem  = p - (q << k);
            half = longint'(1) << (k - 1);
            ex   = ea + eb - 127 + (k - 23);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q  = q / 2;
                ex = ex + 1;
            end
            if (ex >= 255) begin
                r = {sg, 8'hFF, 23'h0};
                f = 3'b010;
            end else if (ex <= 0) begin
                r = {sg, 31'h0};
                f = 3'b001;
            end else r = {sg, 8'(ex), 23'(q)};
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int          c = $urandom_range(0, 99);
        logic [31:0] v = $urandom;
        if (c < 65) v[30:23] = 8'($urandom_range(60, 194));
        else if (c < 75) v = v ^ 32'h0;
        else if (c < 80) v[30:23] = 8'h00;
        else if (c < 85) v[30:0] = {8'hFF, 23'h0};
        else if (c < 88) v[30:23] = 8'hFF;
        else if (c < 94) v[30:23] = 8'($urandom_range(190, 254));
        else v[30:23] = 8'($urandom_range(1, 64));
        if ($urandom_range(0, 9) == 0) v[22:0] = 23'h7FFFFF;
        else if ($urandom_range(0, 9) == 0) v[11:0] = 12'h000;
        return v;
    endfunction

    // present one operation and hold it until accepted
    task automatic send(input logic [31:0] s, input logic [31:0] t,
                        input logic [3:0] tag, input logic [31:0] ed,
                        input logic [2:0] ef);
        bit ok = 0;
        in_s     = s;
        in_t     = t;
        in_tag   = tag;
        exp_d    = ed;
        exp_f    = ef;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk(1'b0, "accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_m(input logic [31:0] s, input logic [31:0] t,
                          input logic [3:0] tag);
        logic [31:0] r;
        logic [2:0]  f;
        model(s, t, r, f);
        send(s, t, tag, r, f);
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (sbq.size() == 0);
        end
        chk(ok, name, 64'(sbq.size()), 64'd0);
    endtask

    // monitor: stability, handshake, in-order results, latency
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            have_hold = 0;
        end else begin
            if (have_hold) begin
                chk(out_valid && out_d == hd && out_tag == ht && out_flags == hf,
                    "hold_stable", {out_valid, out_flags, out_tag, out_d},
                    {1'b1, hf, ht, hd});
                have_hold = 0;
            end
            if (out_valid && !out_ready) begin
                chk(!in_ready, "stall_in_ready", 64'(in_ready), 64'd0);
                have_hold = 1;
                hd = out_d;
                ht = out_tag;
                hf = out_flags;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk(1'b0, "unexpected_output", 64'(out_tag), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk(out_d == e.d && out_tag == e.tag && out_flags == e.fl,
                        "result", {out_flags, out_tag, out_d},
                        {e.fl, e.tag, e.d});
                    lat = cycle - e.cyc - (stalls - e.stl);
                    chk(lat == 3, "latency", 64'(lat), 64'd3);
                end
            end
            if (in_valid && in_ready)
                sbq.push_back('{exp_d, in_tag, exp_f, cycle, stalls});
            if (!in_ready) stalls++;
        end
        cycle++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(!out_valid, "reset_out_valid", 64'(out_valid), 64'd0);
        chk(out_d == 32'h0, "reset_out_d", 64'(out_d), 64'd0);
        chk(out_tag == 4'h0, "reset_out_tag", 64'(out_tag), 64'd0);
        chk(out_flags == 3'b000, "reset_out_flags", 64'(out_flags), 64'd0);
        chk(in_ready, "reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 3'b000);
        send(32'h3F800001, 32'h3FC00000, 4'd1, 32'h3FC00002, 3'b000);
        send(32'h3FFFFFFF, 32'h3F800001, 4'd2, 32'h40000000, 3'b000);
        send(32'h7F000000, 32'h40000000, 4'd3, 32'h7F800000, 3'b010);
        send(32'h00800000, 32'h3F000000, 4'd4, 32'h00000000, 3'b001);
        send(32'h80000001, 32'h3F800000, 4'd6, 32'h80000000, 3'b000);
        send(32'h7F800000, 32'h00000000, 4'd7, 32'h7FC00000, 3'b100);
        send(32'h7F800001, 32'h3F800000, 4'd8, 32'h7FC00001, 3'b000);
        send(32'hFF800000, 32'h40000000, 4'd9, 32'hFF800000, 3'b000);
        send(32'hC0400000, 32'h3F000000, 4'd10, 32'hBFC00000, 3'b000);
        drain("drain_directed");

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_m(rand_op(), rand_op(), 4'(i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 4'hD, 32'h40000000, 3'b000);
        send(32'h3F800000, 32'h40400000, 4'hE, 32'h40400000, 3'b000);
        send(32'h3F800000, 32'h40800000, 4'hF, 32'h40800000, 3'b000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(!out_valid, "post_reset_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h3F800000, 32'h40A00000, 4'h7, 32'h40A00000, 3'b000);
        drain("drain_after_reset");

        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_m(rand_op(), rand_op(), 4'($urandom));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
